// File: rtl/line_flip_ctrl.sv
// Ping-pong line buffer sequencer for the horizontal-mirror video path.
// Optional line-length checking and read masking: define LINE_CHECK_EN.
module line_flip_ctrl #(
    parameter int MAX_W  = 1920,
    parameter int AW     = 11,
    parameter int RD_LAT = 1
) (
    input  logic          pix_1x_clk,
    input  logic          reset_in,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          flip_req,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic          rd_en,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr,
    output logic          de_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          blank_out,
    output logic          flip_active,
    output logic          line_err
);

    localparam int LW = AW + 1;
    localparam logic [LW-1:0] MAXL    = LW'(MAX_W);
    localparam logic [AW-1:0] COL_MAX = AW'(MAX_W - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        FIRST_LINE,
        STREAM
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          de_d;
    logic          vs_d;
    logic [AW-1:0] col;
    logic          full;
    logic          vs_rise;
    logic          de_fall;
    logic          active;
    logic          rd_en_d;
    logic          rd_mask;
    logic [LW-1:0] mir_len;
    logic [LW-1:0] mir_diff;
    logic [3:0]    sr [RD_LAT];

    assign vs_rise = vsync_in & ~vs_d;
    assign de_fall = de_d & ~de_in;
    assign active  = (state != WAIT_FRAME);

`ifdef LINE_CHECK_EN
    logic [LW-1:0] prev_len;
    logic [LW-1:0] len_cur;
    logic          err_q;

    // full means pixel MAX_W-1 was already written this line
    assign len_cur = full ? MAXL : {1'b0, col};

    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
        if (reset_in) begin
            prev_len <= '0;
            err_q    <= 1'b0;
        end else begin
            if (active && de_fall)
                prev_len <= len_cur;
            if (active && ((de_in && full) ||
                (state == STREAM && de_fall && len_cur != prev_len)))
                err_q <= 1'b1;
            else if (vs_rise)
                err_q <= 1'b0;
        end
    end

    assign mir_len  = prev_len;
    assign rd_mask  = ~full & ({1'b0, col} < prev_len);
    assign line_err = err_q;
`else
    assign mir_len  = MAXL;
    assign rd_mask  = 1'b1;
    assign line_err = 1'b0;
`endif

    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
        if (reset_in) begin
            de_d        <= 1'b0;
            vs_d        <= 1'b0;
            col         <= '0;
            full        <= 1'b0;
            wr_bank     <= 1'b0;
            flip_active <= 1'b0;
        end else begin
            de_d <= de_in;
            vs_d <= vsync_in;
            if (vs_rise)
                flip_active <= flip_req;
            if (active) begin
                if (de_fall) begin
                    col     <= '0;
                    full    <= 1'b0;
                    wr_bank <= ~wr_bank;
                end else if (de_in) begin
                    if (col == COL_MAX)
                        full <= 1'b1;
                    else
                        col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < RD_LAT; i++)
                sr[i] <= '0;
        end else begin
            sr[0] <= {de_in, hsync_in, vsync_in, rd_en};
            for (int i = 1; i < RD_LAT; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign {de_out, hsync_out, vsync_out, rd_en_d} = sr[RD_LAT-1];

    assign mir_diff = mir_len - LW'(1) - {1'b0, col};
    assign wr_addr  = col;
    assign rd_addr  = flip_active ? mir_diff[AW-1:0] : col;
    assign rd_bank  = ~wr_bank;

    always_ff @(posedge pix_1x_clk or posedge reset_in) begin
        if (reset_in)
            state <= WAIT_FRAME;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            WAIT_FRAME: if (vs_rise) state_nx = FIRST_LINE;
            FIRST_LINE: if (de_fall) state_nx = STREAM;
            default:    state_nx = state;
        endcase
    end

    always_comb begin
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        blank_out = 1'b1;
        unique case (state)
            FIRST_LINE: wr_en = de_in & ~full;
            STREAM: begin
                wr_en     = de_in & ~full;
                rd_en     = de_in & rd_mask;
                blank_out = de_out & ~rd_en_d;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_flip_ctrl.sv
// Scoreboard bench for line_flip_ctrl: a line-level model pushes the
// expected outputs per driven cycle, a negedge monitor pops and compares.
module tb_line_flip_ctrl;

    localparam int MAX_W = 1920;
    localparam int AW    = 11;
`ifdef LINE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [31:0] RST_V =
        {1'b0, 1'b0, 11'd0, 1'b0, 1'b1, 11'd0, 3'b000, 1'b1, 2'b00};

    logic          pix_1x_clk = 1'b0;
    logic          reset_in   = 1'b1;
    logic          de_in      = 1'b0;
    logic          hsync_in   = 1'b0;
    logic          vsync_in   = 1'b0;
    logic          flip_req   = 1'b0;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic          de_out;
    logic          hsync_out;
    logic          vsync_out;
    logic          blank_out;
    logic          flip_active;
    logic          line_err;
    logic [31:0]   obs;

    line_flip_ctrl dut (
        .pix_1x_clk  (pix_1x_clk),
        .reset_in    (reset_in),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .flip_req    (flip_req),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_addr     (wr_addr),
        .rd_en       (rd_en),
        .rd_bank     (rd_bank),
        .rd_addr     (rd_addr),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .blank_out   (blank_out),
        .flip_active (flip_active),
        .line_err    (line_err)
    );

    always #5 pix_1x_clk = ~pix_1x_clk;

    assign obs = {wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr,
                  de_out, hsync_out, vsync_out, blank_out,
                  flip_active, line_err};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    logic [31:0] sb [$];
    int          sbc [$];
    int          ncyc = 0;

    int m_st, m_col, m_prev;
    bit m_bank, m_flip, m_err;
    bit q_de, q_hs, q_vs, q_rd;

    task automatic model_reset();
        m_st = 0; m_col = 0; m_prev = 0;
        m_bank = 0; m_flip = 0; m_err = 0;
        q_de = 0; q_hs = 0; q_vs = 0; q_rd = 0;
    endtask

    task automatic cyc(input bit de, input bit hs, input bit vs);
        int c, p, lenv;
        bit we, re, blk;
        logic [AW-1:0] wa, ra;
        @(posedge pix_1x_clk);
        #1;
        de_in = de; hsync_in = hs; vsync_in = vs;
        c   = (m_col < MAX_W) ? m_col : MAX_W - 1;
        we  = (m_st != 0) && de && (m_col < MAX_W);
        re  = (m_st == 2) && de && (CHK ? (m_col < m_prev) : 1'b1);
        p   = CHK ? m_prev : MAX_W;
        wa  = AW'(c);
        ra  = m_flip ? AW'(p - 1 - c) : wa;
        blk = (m_st == 2) ? (q_de && !q_rd) : 1'b1;
        sb.push_back({we, m_bank, wa, re, ~m_bank, ra,
                      q_de, q_hs, q_vs, blk, m_flip, m_err});
        sbc.push_back(ncyc);
        ncyc++;
        if (vs && !q_vs) begin
            m_flip = flip_req;
            m_err  = 0;
        end
        if (m_st != 0) begin
            if (de && m_col >= MAX_W && CHK) m_err = 1;
            if (de) m_col++;
            if (q_de && !de) begin
                lenv = (m_col < MAX_W) ? m_col : MAX_W;
                if (m_st == 2 && lenv != m_prev && CHK) m_err = 1;
                m_prev = lenv;
                m_bank = ~m_bank;
                m_col  = 0;
                m_st   = 2;
            end
        end else if (vs && !q_vs) begin
            m_st = 1;
        end
        q_de = de; q_hs = hs; q_vs = vs; q_rd = re;
    endtask

    always @(negedge pix_1x_clk) begin
        logic [31:0] e;
        int c;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            c = sbc.pop_front();
            chk($sformatf("cyc%0d", c), obs, e);
        end
    end

    task automatic do_reset();
        @(posedge pix_1x_clk);
        #1;
        reset_in = 1'b1;
        #1;
        chk("rst_async", obs, RST_V);
        repeat (2) @(posedge pix_1x_clk);
        #1;
        de_in = 0; hsync_in = 0; vsync_in = 0;
        reset_in = 1'b0;
        model_reset();
        #1;
        chk("rst_rel", obs, RST_V);
    endtask

    task automatic blank_gap();
        repeat (4) cyc(0, 0, 0);
        repeat (8) cyc(0, 1, 0);
        repeat (4) cyc(0, 0, 0);
    endtask

    task automatic vsy();
        repeat (4) cyc(0, 0, 0);
        repeat (4) cyc(0, 0, 1);
        repeat (8) cyc(0, 0, 0);
    endtask

    task automatic line(input int n, input int tog);
        for (int i = 0; i < n; i++) begin
            if (i == tog) flip_req = ~flip_req;
            cyc(1, 0, 0);
        end
        blank_gap();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        chk("rst_init", obs, RST_V);
        do_reset();

        flip_req = 1'b1;
        vsy();
        line(1920, -1);
        line(1920, 900);
        line(1920, -1);

        vsy();
        line(1920, -1);
        line(1000, -1);
        line(1920, -1);
        line(2000, -1);
        line(1920, -1);

        vsy();
        line(1920, -1);
        for (int i = 0; i < 500; i++) cyc(1, 0, 0);
        do_reset();

        flip_req = 1'b1;
        vsy();
        line(1920, -1);
        line(1920, -1);
        line(1920, -1);
        line(1920, -1);

        @(negedge pix_1x_clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
